// File: rtl/cop0_pkg.sv
// Shared definitions for the cop0 exception/ERET sequencer slice.
package cop0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_VECTOR,
    ST_ERET
  } cop0_seq_state_t;

  localparam logic [31:0] VECTOR_ADDR_DEF = 32'h80000180;
  localparam int unsigned CAUSE_IRQ_LO    = 8;
  localparam int unsigned CAUSE_IRQ_HI    = 15;

endpackage

// File: rtl/cop0_prio_enc8.sv
// 8-bit lowest-set-bit priority encoder; o_idx is 0 when no bit is set.
module cop0_prio_enc8 (
  input  logic [7:0] i_req,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    // Scan from the top so the last hit written is the lowest set bit.
    for (int unsigned i = 0; i < 8; i++) begin
      if (i_req[7 - i]) o_idx = 3'(7 - i);
    end
  end

endmodule

// File: rtl/cop0_exc_seq.sv
// Exception entry / ERET sequencer: stalls, drains, captures EPC,
// pushes/pops the status IE stack and redirects fetch.
module cop0_exc_seq
  import cop0_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
  parameter int unsigned DRAIN_MAX   = 15,
  parameter int unsigned DRAIN_W     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_req,
  input  logic [31:0] cause,
  input  logic [31:0] status,
  input  logic [31:0] pc_in,
  input  logic [31:0] epc_in,
  input  logic        eret_req,
  input  logic        pipe_empty,
  output logic        stall_out,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        epc_we,
  output logic [31:0] epc_val,
  output logic        status_push,
  output logic        status_pop,
  output logic [2:0]  exc_code,
  output logic        drain_timeout,
  output logic        busy
);

  cop0_seq_state_t    r_state, w_next;
  logic [DRAIN_W-1:0] r_cnt;
  logic [31:0]        r_epc_val;
  logic [31:0]        r_pc_target;
  logic [2:0]         r_exc_code;
  logic               r_timeout;

  logic [7:0]         w_irq_mask;
  logic [2:0]         w_enc_idx;
  logic               w_enc_valid;
  logic               w_drain_done;
  logic               w_idle;
  logic               w_unused_bits;

  assign w_irq_mask = cause[CAUSE_IRQ_HI:CAUSE_IRQ_LO] & status[CAUSE_IRQ_HI:CAUSE_IRQ_LO];

  cop0_prio_enc8 u_prio (
    .i_req   (w_irq_mask),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  assign w_unused_bits = ^{cause[31:16], cause[7:0], status[31:16], status[7:0], w_enc_valid};

  assign w_drain_done = (r_cnt == DRAIN_W'(DRAIN_MAX));
  assign w_idle       = (r_state == ST_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (exc_req)       w_next = ST_DRAIN;
        else if (eret_req) w_next = ST_ERET;
      end
      ST_DRAIN:  if (pipe_empty || w_drain_done) w_next = ST_FLUSH;
      ST_FLUSH:  w_next = ST_VECTOR;
      ST_VECTOR: w_next = ST_IDLE;
      ST_ERET:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_epc_val   <= '0;
      r_pc_target <= '0;
      r_exc_code  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DRAIN) r_cnt <= r_cnt + 1'b1;
      else                     r_cnt <= '0;
      if (w_idle && exc_req) begin
        r_epc_val  <= pc_in;
        r_exc_code <= w_enc_idx;
      end
      if (r_state == ST_DRAIN && w_drain_done) r_timeout <= 1'b1;
      // Redirect target is registered one cycle ahead so it is stable while pc_load is high.
      if (w_next == ST_VECTOR)    r_pc_target <= VECTOR_ADDR;
      else if (w_next == ST_ERET) r_pc_target <= epc_in;
      else                        r_pc_target <= '0;
    end
  end

  assign busy          = !w_idle;
  assign stall_out     = busy | (w_idle & (exc_req | eret_req));
  assign flush         = (r_state == ST_FLUSH) || (r_state == ST_ERET);
  assign pc_load       = (r_state == ST_VECTOR) || (r_state == ST_ERET);
  assign pc_target     = r_pc_target;
  assign epc_we        = (r_state == ST_DRAIN) && (r_cnt == '0);
  assign status_push   = epc_we;
  assign status_pop    = (r_state == ST_ERET);
  assign epc_val       = r_epc_val;
  assign exc_code      = r_exc_code;
  assign drain_timeout = r_timeout;

endmodule
